// File: rtl/mpsoc_dbg_jsp_wb_arbiter.sv
// mpsoc_dbg_jsp_wb_arbiter
// Round-robin Wishbone arbiter sharing the 8-bit/3-bit-address JSP slave among
// NUM_MASTERS cores. An owner keeps the JSP for its whole cyc, so multi-access
// sequences are never interleaved. A watchdog errors out stalled strobes. The
// JSP interrupt is routed to a selectable owner core.
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   m_cyc/stb/we/adr/dat_i    packed master requests (master k: adr[3k+2:3k], dat[8k+7:8k])
//   m_dat_o, m_ack_o, m_err_o read data broadcast, per-master ack/err (owner only)
//   s_*                       JSP slave side
//   int_i, int_owner_i, int_o JSP interrupt and its registered one-hot routing
//   grant_o, timeout_o        registered one-hot owner, watchdog pulse
module mpsoc_dbg_jsp_wb_arbiter #(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                               wb_clk_i,
   input  logic                               wb_rst_i,
   input  logic [NUM_MASTERS-1:0]             m_cyc_i,
   input  logic [NUM_MASTERS-1:0]             m_stb_i,
   input  logic [NUM_MASTERS-1:0]             m_we_i,
   input  logic [3*NUM_MASTERS-1:0]           m_adr_i,
   input  logic [8*NUM_MASTERS-1:0]           m_dat_i,
   output logic [7:0]                         m_dat_o,
   output logic [NUM_MASTERS-1:0]             m_ack_o,
   output logic [NUM_MASTERS-1:0]             m_err_o,
   output logic                               s_cyc_o,
   output logic                               s_stb_o,
   output logic                               s_we_o,
   output logic [2:0]                         s_adr_o,
   output logic [7:0]                         s_dat_o,
   input  logic [7:0]                         s_dat_i,
   input  logic                               s_ack_i,
   input  logic                               s_err_i,
   input  logic                               int_i,
   input  logic [$clog2(NUM_MASTERS)-1:0]     int_owner_i,
   output logic [NUM_MASTERS-1:0]             int_o,
   output logic [NUM_MASTERS-1:0]             grant_o,
   output logic                               timeout_o
);

   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

   typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_e;

   state_e                   state_q, state_d;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]         gidx_q, gidx_d;
   logic [IDX_W-1:0]         ptr_q, ptr_d;
   logic [7:0]               wd_q, wd_d;
   logic [NUM_MASTERS-1:0]   int_q, int_d;

   logic                     found;
   logic [IDX_W-1:0]         cand;
   int unsigned              rr_idx;
   logic [IDX_W-1:0]         ptr_next;
   logic [2:0]               adr_sel;
   logic [7:0]               dat_sel;

   // State and datapath registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
         int_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
         int_q   <= int_d;
      end
   end

   // Owner mux, arbitration, watchdog and next state
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      ptr_d     = ptr_q;
      wd_d      = '0;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      m_dat_o   = '0;
      m_ack_o   = '0;
      m_err_o   = '0;
      timeout_o = 1'b0;
      found     = 1'b0;
      cand      = '0;
      rr_idx    = 0;
      adr_sel   = '0;
      dat_sel   = '0;
      ptr_next  = (32'(gidx_q) == NUM_MASTERS - 1) ? '0 : gidx_q + IDX_W'(1);

      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         if (gidx_q == IDX_W'(k)) begin
            adr_sel = m_adr_i[k*3 +: 3];
            dat_sel = m_dat_i[k*8 +: 8];
         end
      end

      case (state_q)
         IDLE: begin
            // First requester at or after the pointer, wrapping
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
               rr_idx = 32'(ptr_q) + i;
               if (rr_idx >= NUM_MASTERS) rr_idx = rr_idx - NUM_MASTERS;
               if (!found && m_cyc_i[IDX_W'(rr_idx)]) begin
                  found = 1'b1;
                  cand  = IDX_W'(rr_idx);
               end
            end
            if (found) begin
               state_d       = OWN;
               gidx_d        = cand;
               grant_d       = '0;
               grant_d[cand] = 1'b1;
            end
         end
         OWN: begin
            s_cyc_o         = m_cyc_i[gidx_q];
            s_stb_o         = m_stb_i[gidx_q];
            s_we_o          = m_we_i[gidx_q];
            s_adr_o         = adr_sel;
            s_dat_o         = dat_sel;
            m_dat_o         = s_dat_i;
            m_ack_o[gidx_q] = s_ack_i;
            m_err_o[gidx_q] = s_err_i;
            // A slave response in the expiry cycle wins over the watchdog
            if (s_stb_o && !s_ack_i && !s_err_i) begin
               if (wd_q == 8'(TIMEOUT_CYCLES - 1)) begin
                  m_err_o[gidx_q] = 1'b1;
                  timeout_o       = 1'b1;
               end else begin
                  wd_d = wd_q + 8'd1;
               end
            end
            if (!m_cyc_i[gidx_q]) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = ptr_next;
            end else if (timeout_o) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Slave is detached; wait for the owner to give up its cycle
            if (!m_cyc_i[gidx_q]) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = ptr_next;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Interrupt routing; out-of-range owners receive nothing
   always_comb begin
      int_d = '0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         int_d[k] = int_i && (32'(int_owner_i) == k);
      end
   end

   assign grant_o = grant_q;
   assign int_o   = int_q;

endmodule
